// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state encoding and
// the sizing rule for its cycle counter.
package pll_sup_pkg;

  // FSM state encoding (also exported on state_o for debug)
  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STABILIZE = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;
  localparam logic [1:0] ST_HOLD      = 2'd3;

  // Width of a counter that must hold values up to max(stable, hold)
  function automatic int cnt_width(input int stable_cycles, input int hold_cycles);
    int top;
    top = (stable_cycles > hold_cycles) ? stable_cycles : hold_cycles;
    return $clog2(top + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, with a synchronous
// active-low clear that empties both stages.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Shift the asynchronous input through two flops; clear both on clr_n=0
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so both stages sample
    // their inputs before either updates; blocking here would collapse the
    // chain into a single flop.
    if (!clr_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronises and debounces the PLL lock flag,
// generates a clean synchronous active-low reset for downstream logic,
// and counts lock losses seen while running.
// Optional build macro: LOCK_LOSS_STICKY_EN adds clr_sticky / loss_sticky,
// a sticky flag raised on every lock loss and cleared by software.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int STABLE_CYCLES = 4096,  // locked cycles before release, >= 2
  parameter int HOLD_CYCLES   = 64,    // minimum reset hold after a loss, >= 1
  parameter int CNT_W         = 8      // lock-loss counter width
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             locked,
  output logic             sys_rst_n,
  output logic             pll_ok,
  output logic [CNT_W-1:0] loss_count,
  output logic [1:0]       state_o
`ifdef LOCK_LOSS_STICKY_EN
  ,
  input  logic             clr_sticky,
  output logic             loss_sticky
`endif
);

  localparam int CW = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]    HOLD_LAST   = CW'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] LOSS_MAX    = '1;

  logic          lk_s;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  // One counter serves both STABILIZE (stable count) and HOLD (hold count);
  // the two states never overlap and each entry reloads it.
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          loss_evt;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (clk),
    .clr_n (resetn),
    .d     (locked),
    .q     (lk_s)
  );

  // Next-state and counter logic, driven only by the synchronised lock
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    loss_evt  = 1'b0;
    case (state)
      ST_WAIT_LOCK: begin
        if (lk_s) begin
          state_nxt = ST_STABILIZE;
          cnt_nxt   = CW'(1);
        end
      end
      ST_STABILIZE: begin
        if (!lk_s) begin
          // A glitch before release is not a loss; simply start over
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lk_s) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
          loss_evt  = 1'b1;
        end
      end
      ST_HOLD: begin
        // HOLD always runs to completion, even if lock returns early
        if (cnt == HOLD_LAST) begin
          if (lk_s) begin
            state_nxt = ST_STABILIZE;
            cnt_nxt   = CW'(1);
          end else begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; sys_rst_n/pll_ok decode the
  // next state so they change on the same edge the FSM enters/leaves RUN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_WAIT_LOCK;
      cnt        <= '0;
      sys_rst_n  <= 1'b0;
      pll_ok     <= 1'b0;
      loss_count <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sys_rst_n <= (state_nxt == ST_RUN);
      pll_ok    <= (state_nxt == ST_RUN);
      if (loss_evt && (loss_count != LOSS_MAX)) begin
        loss_count <= loss_count + 1'b1;
      end
    end
  end

`ifdef LOCK_LOSS_STICKY_EN
  // Sticky loss flag: a loss on the same edge as a clear wins
  always_ff @(posedge clk) begin
    if (!resetn) begin
      loss_sticky <= 1'b0;
    end else if (loss_evt) begin
      loss_sticky <= 1'b1;
    end else if (clr_sticky) begin
      loss_sticky <= 1'b0;
    end
  end
`endif

  assign state_o = state;

endmodule
